// File: rtl/dmem_responder.sv
// Wait-stated data memory for the MIPS MEM stage: stalls the pipeline, then pulses done.
// Optional request checking (misaligned / read+write) is enabled by DMEM_ERR_CHECK_EN.
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        addr_err
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [IW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          read_q;
    logic          write_q;
    logic [31:0]   mem [DEPTH];

    logic          req;
    logic          commit;
    logic          c_read;
    logic          c_write;
    logic          c_err;
    logic          do_write;
    logic          do_read;
    logic [IW+1:0] c_addr;
    logic [31:0]   c_wdata;
    logic          unused_bits;

    assign req   = mem_read | mem_write;
    assign stall = ((state == IDLE) && req) || (state == WAIT);

    // With zero wait states the access commits straight from IDLE using the live inputs.
    always_comb begin
        c_addr  = addr_q;
        c_wdata = wdata_q;
        c_read  = read_q;
        c_write = write_q;
        commit  = 1'b0;
        if (state == IDLE) begin
            c_addr  = addr[IW+1:0];
            c_wdata = wdata;
            c_read  = mem_read;
            c_write = mem_write;
            commit  = req && (WAIT_CYCLES == 0);
        end else if (state == WAIT) begin
            commit = (cnt == 4'd0);
        end
    end

`ifdef DMEM_ERR_CHECK_EN
    assign c_err = (c_addr[1:0] != 2'b00) || (c_read && c_write);
`else
    assign c_err = 1'b0;
`endif

    assign do_write    = commit && c_write && !c_err;
    assign do_read     = commit && c_read && !c_write && !c_err;
    assign unused_bits = ^{addr, c_addr};

    always_ff @(posedge clk) begin
        if (do_write) mem[c_addr[IW+1:2]] <= c_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            rdata    <= 32'd0;
            done     <= 1'b0;
            addr_err <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
        end else begin
            done     <= 1'b0;
            addr_err <= 1'b0;
            if (do_read) rdata <= mem[c_addr[IW+1:2]];
            if (commit) begin
                done     <= 1'b1;
                addr_err <= c_err;
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q  <= addr[IW+1:0];
                        wdata_q <= wdata;
                        read_q  <= mem_read;
                        write_q <= mem_write;
                        cnt     <= WAIT_LOAD;
                        state   <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) state <= RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        stall, done, addr_err;
    logic        mem_read0 = 1'b0, mem_write0 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0;
    logic [31:0] rdata0;
    logic        stall0, done0, addr_err0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .done(done),
        .addr_err(addr_err)
    );

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read0), .mem_write(mem_write0),
        .addr(addr0), .wdata(wdata0), .rdata(rdata0), .stall(stall0), .done(done0),
        .addr_err(addr_err0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues one request in the next cycle and checks the full 2-wait-state timeline.
    // Returns at the negedge of the RESP cycle with inputs already dropped.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rdata,
                          input logic exp_err, input string tag);
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; addr = a; wdata = d;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check({tag, "_stall"}, {31'd0, stall}, 32'd1);
            check({tag, "_nodone"}, {31'd0, done}, 32'd0);
            @(posedge clk); #1;
        end
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_stall_resp"}, {31'd0, stall}, 32'd0);
        check({tag, "_rdata"}, rdata, exp_rdata);
        check({tag, "_err"}, {31'd0, addr_err}, {31'd0, exp_err});
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdata", rdata, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_err", {31'd0, addr_err}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "t1_wr");
        access(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "t2_rd");
        access(1'b0, 1'b1, 32'h0, 32'h11111111, 32'hDEADBEEF, 1'b0, "t3_wr");
        access(1'b1, 1'b0, 32'h100, 32'h0, 32'h11111111, 1'b0, "t3_rd_alias");
        access(1'b0, 1'b1, 32'h20, 32'h22222222, 32'h11111111, 1'b0, "t4_prep");

        // Inputs change during WAIT and must be ignored.
        @(posedge clk); #1;
        mem_read = 1'b1; addr = 32'h10;
        @(posedge clk); #1;
        addr = 32'h20; mem_write = 1'b1; wdata = 32'hBAD0BAD0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        check("t4_done", {31'd0, done}, 32'd1);
        check("t4_rdata", rdata, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'h20, 32'h0, 32'h22222222, 1'b0, "t4_rd20");

        // Reset during WAIT discards the pending write.
        @(posedge clk); #1;
        mem_write = 1'b1; addr = 32'h10; wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        rst_n = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        check("t5_rst_done", {31'd0, done}, 32'd0);
        check("t5_rst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_no_done", {31'd0, done}, 32'd0);
        end
        check("t5_rdata_rst", rdata, 32'd0);
        access(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "t5_rd");

        access(1'b1, 1'b0, 32'h20, 32'h0, 32'h22222222, 1'b0, "t6_prep");
`ifdef DMEM_ERR_CHECK_EN
        access(1'b1, 1'b0, 32'h13, 32'h0, 32'h22222222, 1'b1, "t6_misalign");
        access(1'b1, 1'b1, 32'h30, 32'h33333333, 32'h22222222, 1'b1, "t7_rdwr");
`else
        access(1'b1, 1'b0, 32'h13, 32'h0, 32'hDEADBEEF, 1'b0, "t6_misalign");
        access(1'b1, 1'b1, 32'h30, 32'h33333333, 32'hDEADBEEF, 1'b0, "t7_rdwr");
        access(1'b1, 1'b0, 32'h30, 32'h0, 32'h33333333, 1'b0, "t7_rd30");
`endif

        // Zero wait states: done one cycle after the request.
        @(posedge clk); #1;
        mem_write0 = 1'b1; addr0 = 32'h8; wdata0 = 32'h00000005;
        @(negedge clk);
        check("w0_wr_stall", {31'd0, stall0}, 32'd1);
        check("w0_wr_nodone", {31'd0, done0}, 32'd0);
        @(posedge clk); #1;
        mem_write0 = 1'b0;
        @(negedge clk);
        check("w0_wr_done", {31'd0, done0}, 32'd1);
        check("w0_wr_stall_resp", {31'd0, stall0}, 32'd0);
        check("w0_wr_rdata", rdata0, 32'd0);
        @(posedge clk); #1;
        mem_read0 = 1'b1; addr0 = 32'h8;
        @(negedge clk);
        check("w0_rd_stall", {31'd0, stall0}, 32'd1);
        check("w0_rd_nodone", {31'd0, done0}, 32'd0);
        @(posedge clk); #1;
        mem_read0 = 1'b0;
        @(negedge clk);
        check("w0_rd_done", {31'd0, done0}, 32'd1);
        check("w0_rd_rdata", rdata0, 32'h00000005);
        check("w0_rd_err", {31'd0, addr_err0}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("w0_done_pulse", {31'd0, done0}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
